// File: rtl/replica_path_monitor.sv
// replica_path_monitor
// Periodically launches a transition into the critical-path replica, samples
// its output one (and optionally two) cycles later, and classifies the result
// as on-time, late or stuck. Late results are counted over a fixed window of
// measurements. A window whose late count reaches THRESH raises a sticky
// slow-down request toward the clock/stall controller.
//
// Build option: REPLICA_MON_STUCK_CHECK_EN
//   defined   - a second sample cycle exists. A replica that misses both
//               samples is "stuck": it sets the sticky fault_o and is not
//               counted as late.
//   undefined - single sample only. Any miss counts as late, and fault_o
//               is tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | not measuring; busy_o low
// WAIT    | interval countdown between measurements
// LAUNCH  | replica input toggles at the closing edge; expected value latched
// SAMPLE1 | first sample of replica output at the closing edge
// SAMPLE2 | second sample (stuck-check build only)
// EVAL    | classify, update window counters, window-end decision

module replica_path_monitor #(
   parameter  int INTERVAL       = 4,
   parameter  int WINDOW         = 8,
   parameter  int THRESH         = 2,
   parameter  int REPLICA_INVERT = 0,
   localparam int CW             = $clog2(WINDOW + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          enable_i,
   output logic          replica_in_o,
   input  logic          replica_out_i,
   input  logic          slow_ack_i,
   output logic          slow_req_o,
   output logic          fault_o,
   output logic          late_pulse_o,
   output logic [CW-1:0] late_count_o,
   output logic          busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAUNCH,
      S_SAMPLE1,
      S_SAMPLE2,
      S_EVAL
   } state_e;

   localparam logic [7:0]    RELOAD  = 8'(INTERVAL - 1);
   localparam logic [CW-1:0] WIN     = CW'(WINDOW);
   localparam logic [CW-1:0] THR     = CW'(THRESH);
   localparam logic          INV_BIT = (REPLICA_INVERT != 0);

   state_e        state_q, state_d;
   logic [7:0]    ival_q, ival_d;
   logic          rin_q, rin_d;
   logic          exp_q, exp_d;
   logic          s1_q, s1_d;
   logic [CW-1:0] meas_q, meas_d;
   logic [CW-1:0] late_q, late_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          slow_q, slow_d;
   logic          pulse_q, pulse_d;
   logic          slow_set;

   logic          is_late;
   logic [CW-1:0] late_sum;
   logic [CW-1:0] meas_inc;

`ifdef REPLICA_MON_STUCK_CHECK_EN
   logic          s2_q, s2_d;
   logic          fault_q, fault_d;
   logic          is_stuck;

   assign is_late  = (s1_q != exp_q) && (s2_q == exp_q);
   assign is_stuck = (s1_q != exp_q) && (s2_q != exp_q);
`else
   assign is_late  = (s1_q != exp_q);
`endif

   // Late count saturates at WINDOW so the counter can never wrap.
   assign late_sum = (is_late && (late_q != WIN)) ? late_q + CW'(1) : late_q;
   assign meas_inc = meas_q + CW'(1);

   // Next-state and datapath decode for the measurement sequencer.
   always_comb begin
      state_d  = state_q;
      ival_d   = ival_q;
      rin_d    = rin_q;
      exp_d    = exp_q;
      s1_d     = s1_q;
      meas_d   = meas_q;
      late_d   = late_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      slow_set = 1'b0;
`ifdef REPLICA_MON_STUCK_CHECK_EN
      s2_d     = s2_q;
      fault_d  = fault_q;
`endif

      // EVAL always completes its bookkeeping; everywhere else a dropped
      // enable abandons the measurement and the partial window.
      if (!enable_i && (state_q != S_EVAL)) begin
         state_d = S_IDLE;
         meas_d  = '0;
         late_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_WAIT;
               ival_d  = RELOAD;
            end
            S_WAIT: begin
               if (ival_q == 8'd0) begin
                  state_d = S_LAUNCH;
               end else begin
                  ival_d = ival_q - 8'd1;
               end
            end
            S_LAUNCH: begin
               rin_d   = ~rin_q;
               exp_d   = ~rin_q ^ INV_BIT;
               state_d = S_SAMPLE1;
            end
            S_SAMPLE1: begin
               s1_d = replica_out_i;
`ifdef REPLICA_MON_STUCK_CHECK_EN
               state_d = S_SAMPLE2;
`else
               state_d = S_EVAL;
`endif
            end
`ifdef REPLICA_MON_STUCK_CHECK_EN
            S_SAMPLE2: begin
               s2_d    = replica_out_i;
               state_d = S_EVAL;
            end
`endif
            S_EVAL: begin
               pulse_d = is_late;
`ifdef REPLICA_MON_STUCK_CHECK_EN
               if (is_stuck) begin
                  fault_d = 1'b1;
               end
`endif
               if (meas_inc == WIN) begin
                  cnt_d    = late_sum;
                  slow_set = (late_sum >= THR);
                  meas_d   = '0;
                  late_d   = '0;
               end else begin
                  meas_d = meas_inc;
                  late_d = late_sum;
               end
               ival_d  = RELOAD;
               state_d = enable_i ? S_WAIT : S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // A window-end set in the same cycle as an acknowledge keeps the request.
      if (slow_set) begin
         slow_d = 1'b1;
      end else if (slow_ack_i) begin
         slow_d = 1'b0;
      end else begin
         slow_d = slow_q;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ival_q  <= '0;
         rin_q   <= 1'b0;
         exp_q   <= 1'b0;
         s1_q    <= 1'b0;
         meas_q  <= '0;
         late_q  <= '0;
         cnt_q   <= '0;
         slow_q  <= 1'b0;
         pulse_q <= 1'b0;
`ifdef REPLICA_MON_STUCK_CHECK_EN
         s2_q    <= 1'b0;
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ival_q  <= ival_d;
         rin_q   <= rin_d;
         exp_q   <= exp_d;
         s1_q    <= s1_d;
         meas_q  <= meas_d;
         late_q  <= late_d;
         cnt_q   <= cnt_d;
         slow_q  <= slow_d;
         pulse_q <= pulse_d;
`ifdef REPLICA_MON_STUCK_CHECK_EN
         s2_q    <= s2_d;
         fault_q <= fault_d;
`endif
      end
   end

   assign replica_in_o = rin_q;
   assign slow_req_o   = slow_q;
   assign late_pulse_o = pulse_q;
   assign late_count_o = cnt_q;
   assign busy_o       = (state_q != S_IDLE);
`ifdef REPLICA_MON_STUCK_CHECK_EN
   assign fault_o      = fault_q;
`else
   assign fault_o      = 1'b0;
`endif

endmodule
